// File: rtl/serial_sub_pkg.sv
// Shared constants and types for the bit-serial unsigned subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/serial_unsigned_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_unsigned_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock; optional clamp-to-zero via SERIAL_SUB_SAT_EN.
// Latency: done pulses WIDTH+1 cycles after the cycle in which start is accepted.
// Backpressure: start is ignored while busy; results hold in dout/bout until the next completion.
module serial_unsigned_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fs_d;
    logic               fs_bout;
    logic               last_bit;
    logic [WIDTH-1:0]   res_shift;
    logic [WIDTH-1:0]   final_dout;

    // Single bit-slice shared by every RUN cycle; operands present their LSB.
    full_subtractor u_full_subtractor (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_shift = (res_q >> 1) | {fs_d, {(WIDTH-1){1'b0}}};

`ifdef SERIAL_SUB_SAT_EN
    assign final_dout = fs_bout ? '0 : res_shift;
`else
    assign final_dout = res_shift;
`endif

    // Next-state and datapath: load on start, shift one bit per RUN cycle, publish on last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    dout_d  = final_dout;
                    bout_d  = fs_bout;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over any start or run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_unsigned_subtractor.sv
// Self-checking bench for serial_unsigned_subtractor with a result scoreboard.
// Latency: expects done WIDTH+1 cycles after the start cycle, busy for WIDTH cycles.
// Backpressure: exercises ignored mid-run start, reset abort and back-to-back start.
module tb_serial_unsigned_subtractor;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         bout;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_unsigned_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .bout  (bout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] diff;
        exp_t       e;
        diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.b  = diff[W];
        e.d  = diff[W-1:0];
`ifdef SERIAL_SUB_SAT_EN
        if (e.b) e.d = '0;
`endif
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin : sb_pop
            exp_t e;
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("dout", {32'd0, dout}, {32'd0, e.d});
                check("bout", {63'd0, bout}, {63'd0, e.b});
            end
        end
    end

    // Drive start with operands for one cycle, then scramble inputs to prove they were latched.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        sb.push_back(model(a, b, bi));
        start = 1'b1;
        in1   = a;
        in2   = b;
        bin   = bi;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        bin   = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for done; returns at the negedge of the done cycle. Optionally pokes start mid-run.
    task automatic wait_done(input string tag, input int poke_at);
        int lat;
        int nbusy;
        lat   = -1;
        nbusy = 0;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
            if (k == poke_at) begin
                start = 1'b1;
                in1   = $urandom;
                in2   = $urandom;
                bin   = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'(W));
    endtask

    // Full operation followed by a check that done was a single-cycle pulse.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input int poke_at);
        launch(a, b, bi);
        wait_done("op", poke_at);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_not_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        bin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dout", {32'd0, dout}, 64'd0);
        check("rst_bout", {63'd0, bout}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases
        run(32'd10, 32'd3, 1'b0, 0);
        run(32'd3, 32'd10, 1'b0, 0);
        run(32'd0, 32'd0, 1'b1, 0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run(32'h8000_0000, 32'h0000_0001, 1'b1, 0);

        // start pulsed at cycle 10 of a run must be ignored
        run(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 10);

        // reset in the middle of a run aborts it with no done pulse
        launch(32'd100, 32'd7, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_dout", {32'd0, dout}, 64'd0);
        check("abort_bout", {63'd0, bout}, 64'd0);
        ndone = 0;
        for (int k = 0; k < W + 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        @(posedge clk);
        #1;
        run(32'd100, 32'd7, 1'b1, 0);

        // back-to-back: start held in the DONE cycle
        launch(32'd1234, 32'd34, 1'b0);
        wait_done("b2b_first", 0);
        sb.push_back(model(32'd5, 32'd5, 1'b0));
        start = 1'b1;
        in1   = 32'd5;
        in2   = 32'd5;
        bin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", 0);
        @(posedge clk);
        #1;

        // random operands
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (i == 0) ? ra : $urandom;
            run(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_unsigned_subtractor.md
SERIAL_UNSIGNED_SUBTRACTOR -- requirements
Module: serial_unsigned_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction.
REQ-005 SHALL have port in1  input  WIDTH  minuend, unsigned.
REQ-006 SHALL have port in2  input  WIDTH  subtrahend, unsigned.
REQ-007 SHALL have port bin  input  1  borrow-in, subtracted at bit 0.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port dout  output  WIDTH  difference in1 - in2 - bin.
REQ-011 SHALL have port bout  output  1  borrow-out; 1 = unsigned underflow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch in1, in2, bin, clear the bit counter, clear the result register, and enter RUN next cycle.
REQ-014 start SHALL be ignored while in RUN; latched operands are not disturbed.
REQ-015 Each RUN cycle SHALL process one bit, LSB first: d = a^b^br, br_next = (~a&b) | (~(a^b)&br).
REQ-016 Each d SHALL shift into the result register from the MSB side; both operand registers shift right by one.
REQ-017 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; with start at edge N, done=1 in the cycle after edge N+WIDTH+1.
REQ-018 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL go to IDLE unless start=1 (REQ-013).
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 dout and bout SHALL update only on entry to DONE and hold until the next entry to DONE or reset.
REQ-021 bout SHALL equal the final borrow after bit WIDTH-1.
REQ-022 Without saturation, dout SHALL equal (in1 - in2 - bin) mod 2^WIDTH.

Reset
REQ-023 rst=1 SHALL force state IDLE, busy=0, done=0, dout=0, bout=0, counter=0, borrow=0.
REQ-024 rst SHALL take priority over start and abort any RUN in progress; no done pulse follows.

Configuration
REQ-025 Macro SERIAL_SUB_SAT_EN, when defined, SHALL clamp dout to 0 when bout=1; bout is still reported as 1.
REQ-026 Without SERIAL_SUB_SAT_EN, dout SHALL wrap per REQ-022; no clamp logic is generated.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the default WIDTH constant, the FSM state enum (IDLE, RUN, DONE), and the counter width ($clog2 of WIDTH+1).
REQ-028 The 1-bit combinational full_subtractor (a, b, bin -> d, bout) SHALL be a separate sub-module instantiated once.

Verification
REQ-029 in1=10, in2=3, bin=0, start at cycle 0 -> busy cycles 1..32, done at cycle 33, dout=7, bout=0.
REQ-030 in1=3, in2=10, bin=0 -> dout=0xFFFFFFF9, bout=1; with SERIAL_SUB_SAT_EN: dout=0, bout=1.
REQ-031 in1=0, in2=0, bin=1 -> dout=0xFFFFFFFF, bout=1 (sat: 0); in1=0xFFFFFFFF, in2=0xFFFFFFFF, bin=0 -> dout=0, bout=0.
REQ-032 start with new operands pulsed at cycle 10 of a running operation -> ignored; first result unchanged, done at cycle 33.
REQ-033 rst asserted at cycle 15 of RUN -> next cycle IDLE, all outputs 0, no done; a fresh start then completes normally.
REQ-034 start held high in the DONE cycle with in1=5, in2=5 -> first done pulses, second operation runs back-to-back, second done WIDTH+1 cycles later with dout=0, bout=0.
